// File: rtl/register_file_pkg.sv
// Shared constants and types for the 32 x 64-bit register file.
// Imported by the register file RTL and its bench.
package regfile_pkg;

  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 31;
  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;

  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/register_file_if.sv
// Read/write bus of the register file.
// The master drives indices, write data and enable; the slave returns both read buses.
interface register_file_if #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
);

  logic [DATA_WIDTH-1:0] BusW;
  logic [ADDR_WIDTH-1:0] RA;
  logic [ADDR_WIDTH-1:0] RB;
  logic [ADDR_WIDTH-1:0] RW;
  logic                  RegWr;
  logic [DATA_WIDTH-1:0] BusA;
  logic [DATA_WIDTH-1:0] BusB;

  modport master (
    output BusW, RA, RB, RW, RegWr,
    input  BusA, BusB
  );

  modport slave (
    input  BusW, RA, RB, RW, RegWr,
    output BusA, BusB
  );

endinterface

// File: rtl/register_file_read_port.sv
// Combinational read port: full-width mux over the register array.
// The hardwired-zero index always returns zero.
module register_file_read_port #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int ZERO_REG   = regfile_pkg::ZERO_REG
) (
  input  logic [DATA_WIDTH-1:0] regs [1<<ADDR_WIDTH],
  input  logic [ADDR_WIDTH-1:0] idx,
  output logic [DATA_WIDTH-1:0] data
);
  import regfile_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ZIDX =
    ADDR_WIDTH'(ZERO_REG);

  always_comb begin
    data = '0;
    if (idx != ZIDX) begin
      data = regs[idx];
    end
  end

endmodule

// File: rtl/register_file.sv
// Dual-read, single-write register file; writes commit on the falling edge.
// Storage clears asynchronously; write enable waits for a synchronized release.
module register_file #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int ZERO_REG   = regfile_pkg::ZERO_REG
) (
  input logic            Clk,
  input logic            Reset_n,
  register_file_if.slave bus
);
  import regfile_pkg::*;

  localparam int NREGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZIDX =
    ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic [1:0]            rst_sync;
  logic                  wr_en;

  // Release from reset is re-timed to the write edge.
  always_ff @(negedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign wr_en = rst_sync[1] && bus.RegWr
              && (bus.RW != ZIDX);

  always_ff @(negedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[bus.RW] <= bus.BusW;
    end
  end

  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_port_a (
    .regs (regs),
    .idx  (bus.RA),
    .data (bus.BusA)
  );

  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_port_b (
    .regs (regs),
    .idx  (bus.RB),
    .data (bus.BusB)
  );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected reads,
// a monitor pops and compares them against the live read buses.
module tb_register_file;
  import regfile_pkg::*;

  logic clk;
  logic rst_n;
  logic sample;

  int checks = 0;
  int errors = 0;

  reg_data_t model [32];

  reg_data_t exp_a [$];
  reg_data_t exp_b [$];
  string     exp_n [$];

  register_file_if #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) bus ();

  register_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic reg_data_t mrd(int idx);
    if (idx == 31) return '0;
    return model[idx];
  endfunction

  function automatic reg_data_t bcd(int n);
    return reg_data_t'((n / 10) * 16 + (n % 10));
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic set_in(int ra, int rb, int rw,
                        reg_data_t bw, bit we);
    bus.RA    = reg_idx_t'(ra);
    bus.RB    = reg_idx_t'(rb);
    bus.RW    = reg_idx_t'(rw);
    bus.BusW  = bw;
    bus.RegWr = we;
  endtask

  task automatic expect_now(string name);
    exp_a.push_back(mrd(int'(bus.RA)));
    exp_b.push_back(mrd(int'(bus.RB)));
    exp_n.push_back(name);
    #1 sample = 1'b1;
    #1 sample = 1'b0;
  endtask

  task automatic fall();
    @(negedge clk);
    if (rst_n && bus.RegWr && int'(bus.RW) != 31)
      model[int'(bus.RW)] = bus.BusW;
    #1;
  endtask

  task automatic cycle(int ra, int rb, int rw,
                       reg_data_t bw, bit we,
                       string name);
    @(posedge clk);
    #1 set_in(ra, rb, rw, bw, we);
    expect_now({name, "_pre"});
    fall();
    expect_now({name, "_post"});
  endtask

  initial begin
    reg_data_t ea, eb;
    string nm;
    forever begin
      @(posedge sample);
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL underflow: sample with empty queue");
      end else begin
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        nm = exp_n.pop_front();
        checks++;
        if (bus.BusA !== ea) begin
          errors++;
          $display("FAIL %s BusA RA=%0d got %h exp %h",
                   nm, bus.RA, bus.BusA, ea);
        end
        checks++;
        if (bus.BusB !== eb) begin
          errors++;
          $display("FAIL %s BusB RB=%0d got %h exp %h",
                   nm, bus.RB, bus.BusB, eb);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ra, rw;
    sample = 1'b0;
    rst_n  = 1'b0;
    clear_model();
    set_in(31, 31, 0, '0, 1'b0);

    repeat (3) @(posedge clk);
    #1 expect_now("rst_zero");
    set_in(0, 30, 0, '0, 1'b0);
    expect_now("rst_regs");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    cycle(31, 31, 31, 64'h1234_5678, 1'b1, "zero_init");

    for (int n = 0; n <= 30; n++)
      cycle(n, 31, n, bcd(n), 1'b1, "fill");

    for (int k = 1; k < 30; k += 2)
      cycle(k, k + 1, 0, '0, 1'b0, "pair");

    cycle(1, 2, 1, 64'h1234_5678, 1'b1, "rw_same");
    cycle(3, 4, 3, 64'h1234_5678, 1'b0, "no_wr");
    cycle(31, 31, 31, 64'h31, 1'b1, "zero_wr");

    for (int i = 0; i < 400; i++) begin
      rw = int'($urandom_range(0, 31));
      ra = ($urandom % 2 == 0) ? rw
         : int'($urandom_range(0, 31));
      cycle(ra, int'($urandom_range(0, 31)), rw,
            {$urandom, $urandom}, 1'($urandom % 2),
            "rand");
    end

    cycle(5, 6, 5, 64'h5555_AAAA_0F0F_F0F0, 1'b1, "pre_rst");
    @(posedge clk);
    #1 set_in(5, 6, 5, {$urandom, $urandom}, 1'b1);
    expect_now("rst_before");
    rst_n = 1'b0;
    clear_model();
    #1 expect_now("rst_async");
    fall();
    expect_now("rst_edge");
    @(posedge clk);
    #1 set_in(5, 6, 0, '0, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    cycle(5, 6, 5, 64'hAA, 1'b1, "rst_rel_wr");
    cycle(5, 5, 0, '0, 1'b0, "rst_rel_rd");

    #5;
    if (exp_a.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d left, exp 0", exp_a.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Dual-read, single-write register file holding 32 registers of 64 bits for the datapath's operand fetch and writeback stages. Register 31 is the hardwired zero register: it always reads zero, and writes to it are discarded. Reads are combinational. Writes commit on the falling edge of the clock so that a value written in one cycle is readable on the following rising edge.

## Interface
- DATA_WIDTH, default 64: register and bus width.
- ADDR_WIDTH, default 5: register index width (2^ADDR_WIDTH registers).
- ZERO_REG, default 31: index of the hardwired-zero register.

Ports:
- Clk  input  1  clock.
- Reset_n  input  1  one clock; reset is asynchronous and active-low.
- BusW  input  DATA_WIDTH  write data.
- RA  input  ADDR_WIDTH  read index for port A.
- RB  input  ADDR_WIDTH  read index for port B.
- RW  input  ADDR_WIDTH  write index.
- RegWr  input  1  write enable.
- BusA  output  DATA_WIDTH  contents of register RA.
- BusB  output  DATA_WIDTH  contents of register RB.

## Operation
- Storage is 2^ADDR_WIDTH registers of DATA_WIDTH bits each.
- Write: on the falling edge of Clk, when RegWr=1 and RW != ZERO_REG, the register at RW is loaded with BusW.
  - When RegWr=0, no register changes.
  - When RW=ZERO_REG, the write is silently dropped.
- Read: BusA = (RA==ZERO_REG) ? 0 : reg[RA]. BusB is defined the same way from RB.
  - Both read ports are purely combinational and independent.
  - RA and RB may be equal.
- There is no write-to-read bypass.
  - Before the write edge, a read of RW returns the old value.
  - After the edge, the read returns the new value.
- Reset: while Reset_n=0, all registers clear to 0 asynchronously and writes are ignored. BusA and BusB therefore read 0.
- Reset release is synchronized to the storage clock edge, so the first write cannot land in the same edge as deassertion.
- Reset asserted in the middle of operation overrides a concurrent write: the register clears and does not take BusW.

## Timing
- Write latency: data is committed at the first falling Clk edge with RegWr=1. It is visible on BusA/BusB immediately after that edge, combinationally.
- Read latency: zero cycles. BusA/BusB follow RA/RB/register contents with combinational delay only, settling well within half a clock period.
- Inputs RW, BusW and RegWr must be stable around the falling edge.
- The rising edge has no function in this block.
- Reset values: all registers are 0; BusA and BusB are 0.

## Structure
- Shared package `regfile_pkg` holds:
  - the constants NUM_REGS=32, ZERO_REG=31, DATA_WIDTH=64, ADDR_WIDTH=5;
  - typedef `reg_idx_t` (logic [4:0]);
  - typedef `reg_data_t` (logic [63:0]).
- One natural sub-module is `register_file_read_port`: a combinational 32:1 DATA_WIDTH mux with zero-register masking. It is instantiated twice, once for A and once for B.
- The storage array and the write decode stay in the top module.

## Test plan
- After reset, with RA=RB=31 -> BusA=BusB=0. Then RW=31, BusW=0x12345678, RegWr=1, one falling edge -> BusA=BusB=0 still.
- Write register n with value n (hex pattern 0x0..0x30) for n=0..30 on successive falling edges. Then read pairs (1,2), (3,4) … (29,30) -> each bus returns its index's written value, e.g. RA=9 gives 0x9 and RB=10 gives 0x10.
- Same-register read/write, RA=1, RB=2, RW=1, BusW=0x12345678, RegWr=1:
  - before the falling edge -> BusA=0x1, BusB=0x2;
  - after the edge -> BusA=0x12345678, BusB=0x2.
- RegWr=0, RW=3, BusW=0x12345678, RA=3, RB=4, clock a full cycle -> BusA stays 0x3 and BusB stays 0x4. No register changes.
- Write 0x31 to RW=31 with RegWr=1, then read RA=31 -> BusA=0.
- With registers loaded, assert Reset_n=0 mid-cycle while RegWr=1, RW=5 -> BusA for RA=5 becomes 0 immediately and stays 0 after the falling edge. Release reset, write 0xAA to register 5 -> reads 0xAA.
